// File: rtl/alu_muldiv_unit.sv
// EX-stage ALU with operand forwarding plus a sequential radix-2 multiply/divide
// unit that writes HI/LO after WIDTH+1 busy cycles.
module alu_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  input  logic [WIDTH-1:0] read_data_1,
  input  logic [WIDTH-1:0] read_data_2,
  input  logic [WIDTH-1:0] EX_MEM_alu_result,
  input  logic [WIDTH-1:0] MEM_WB_read_data,
  input  logic [WIDTH-1:0] ins_15_0,
  input  logic [2:0]       alu_op,
  input  logic             alu_src,
  input  logic             valid_in,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic [WIDTH-1:0] write_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic                 div_q, div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;

  logic [WIDTH-1:0]     a_op, b_fwd, b_op;
  logic [5:0]           funct;
  logic                 md_funct, accept;
  logic                 op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 lt_s, lt_u;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  // Operand forwarding; 2'b11 falls back to the register file.
  always_comb begin
    case (ForwardA)
      2'b10:   a_op = EX_MEM_alu_result;
      2'b01:   a_op = MEM_WB_read_data;
      default: a_op = read_data_1;
    endcase
    case (ForwardB)
      2'b10:   b_fwd = EX_MEM_alu_result;
      2'b01:   b_fwd = MEM_WB_read_data;
      default: b_fwd = read_data_2;
    endcase
    b_op = alu_src ? ins_15_0 : b_fwd;
  end

  assign write_data = b_fwd;
  assign funct      = ins_15_0[5:0];
  assign lt_s       = $signed(a_op) < $signed(b_op);
  assign lt_u       = a_op < b_op;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      3'b000: alu_result = a_op + b_op;
      3'b001: alu_result = a_op - b_op;
      3'b011: alu_result = a_op & b_op;
      3'b100: alu_result = a_op | b_op;
      3'b101: alu_result = {{(WIDTH-1){1'b0}}, lt_s};
      3'b010: begin
        case (funct)
          FN_ADD:  alu_result = a_op + b_op;
          FN_SUB:  alu_result = a_op - b_op;
          FN_AND:  alu_result = a_op & b_op;
          FN_OR:   alu_result = a_op | b_op;
          FN_SLT:  alu_result = {{(WIDTH-1){1'b0}}, lt_s};
          FN_SLTU: alu_result = {{(WIDTH-1){1'b0}}, lt_u};
          FN_MFHI: alu_result = hi_q;
          FN_MFLO: alu_result = lo_q;
          default: alu_result = '0;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // funct 0x18..0x1B: bit0 selects unsigned, bit1 selects divide.
  always_comb begin
    md_funct  = (funct[5:2] == 4'b0110);
    accept    = valid_in && (alu_op == 3'b010) && md_funct && (state_q == S_IDLE);
    op_signed = ~funct[0];
    a_neg     = op_signed & a_op[WIDTH-1];
    b_neg     = op_signed & b_op[WIDTH-1];
    a_mag     = a_neg ? ('0 - a_op) : a_op;
    b_mag     = b_neg ? ('0 - b_op) : b_op;
  end

  // p_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, b_q} : '0);
    div_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, b_q};
    prod_fix  = neg_res_q ? ('0 - p_q) : p_q;
    quo_fix   = neg_res_q ? ('0 - p_q[WIDTH-1:0]) : p_q[WIDTH-1:0];
    rem_fix   = neg_rem_q ? ('0 - p_q[2*WIDTH-1:WIDTH]) : p_q[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    p_d       = p_q;
    b_d       = b_q;
    a_d       = a_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          p_d       = {{WIDTH{1'b0}}, a_mag};
          b_d       = b_mag;
          a_d       = a_op;
          div_d     = funct[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          dbz_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (div_q) begin
          if (div_diff[WIDTH]) begin
            p_d = {div_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
          end else begin
            p_d = {div_diff[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
          end
        end else begin
          p_d = {mul_sum, p_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (div_q && (b_q == '0)) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else if (div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      b_q       <= '0;
      a_q       <= '0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      b_q       <= b_d;
      a_q       <= a_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Randomized self-checking bench for alu_muldiv_unit against an arithmetic reference model.
module tb_alu_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] read_data_1, read_data_2, EX_MEM_alu_result, MEM_WB_read_data, ins_15_0;
  logic [2:0]  alu_op;
  logic        alu_src, valid_in;
  logic [31:0] alu_result, write_data, hi, lo;
  logic        zero, busy, done, div_by_zero;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dbz = 1'b0;
  logic [31:0] p_hi, p_lo;
  logic        p_dbz;

  alu_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .EX_MEM_alu_result(EX_MEM_alu_result), .MEM_WB_read_data(MEM_WB_read_data),
    .ins_15_0(ins_15_0), .alu_op(alu_op), .alu_src(alu_src), .valid_in(valid_in),
    .alu_result(alu_result), .zero(zero), .write_data(write_data),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sel_src(input logic [1:0] fwd, input logic [31:0] rf,
                                          input logic [31:0] exmem, input logic [31:0] memwb);
    if (fwd == 2'b10) return exmem;
    if (fwd == 2'b01) return memwb;
    return rf;
  endfunction

  function automatic logic [31:0] alu_model(input logic [2:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] h, input logic [31:0] l);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd2: begin
        case (f)
          6'h20: return a + b;
          6'h22: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          6'h2B: return (a < b) ? 32'd1 : 32'd0;
          6'h10: return h;
          6'h12: return l;
          default: return 32'd0;
        endcase
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_muldiv(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] h, output logic [31:0] l, output logic z);
    logic signed [63:0] sa, sb, r64;
    logic [63:0] u64;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    z  = 1'b0;
    case (f)
      6'h18: begin r64 = sa * sb; {h, l} = r64; end
      6'h19: begin u64 = {32'd0, a} * {32'd0, b}; {h, l} = u64; end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; z = 1'b1;
        end else if (f == 6'h1A) begin
          r64 = sa / sb; l = r64[31:0];
          r64 = sa % sb; h = r64[31:0];
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endtask

  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    ForwardA = 2'b00; ForwardB = 2'b00; alu_src = 1'b0; alu_op = 3'b010;
    ins_15_0 = {26'd0, f}; read_data_1 = a; read_data_2 = b; valid_in = 1'b1;
    #1;
    n_checks++;
    if (alu_result !== 32'd0) begin
      n_fails++; $display("FAIL muldiv_result_zero: got %h expected 0", alu_result);
    end
    model_muldiv(f, a, b, p_hi, p_lo, p_dbz);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_done(input int exp_busy);
    int  nb = 0;
    bit  seen = 0;
    n_checks++;
    if (div_by_zero !== 1'b0) begin
      n_fails++; $display("FAIL dbz_clear_on_accept: got %b expected 0", div_by_zero);
    end
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin seen = 1; break; end
      if (busy === 1'b1) nb++;
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fails++; $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
    n_checks++;
    if (nb != exp_busy) begin
      n_fails++; $display("FAIL busy_cycles: got %0d expected %0d", nb, exp_busy);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++; $display("FAIL busy_at_done: got %b expected 0", busy);
    end
    n_checks++;
    if ({hi, lo, div_by_zero} !== {p_hi, p_lo, p_dbz}) begin
      n_fails++; $display("FAIL muldiv_result: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                          hi, lo, div_by_zero, p_hi, p_lo, p_dbz);
    end
    m_hi = p_hi; m_lo = p_lo; m_dbz = p_dbz;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin
      n_fails++; $display("FAIL done_pulse_width: got %b expected 0", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b0; alu_op = 3'b000; alu_src = 1'b0;
    ForwardA = 2'b00; ForwardB = 2'b00; ins_15_0 = '0;
    read_data_1 = 32'd11; read_data_2 = 32'd22; EX_MEM_alu_result = '0; MEM_WB_read_data = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_fails++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
    end
    n_checks++;
    if ({hi, lo} !== 64'd0) begin
      n_fails++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    n_checks++;
    if (alu_result !== 32'd33 || write_data !== 32'd22) begin
      n_fails++; $display("FAIL comb_during_reset: got res=%h wd=%h expected res=21 wd=16",
                          alu_result, write_data);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_alu_directed();
    ForwardA = 2'b10; ForwardB = 2'b00; EX_MEM_alu_result = 32'd50; read_data_1 = 32'd999;
    read_data_2 = 32'd20; alu_src = 1'b0; alu_op = 3'b010; ins_15_0 = 32'h20; valid_in = 1'b1;
    #1;
    n_checks++;
    if (alu_result !== 32'd70 || zero !== 1'b0) begin
      n_fails++; $display("FAIL fwd_add: got res=%0d zero=%b expected 70 zero=0", alu_result, zero);
    end
    @(negedge clk);
    valid_in = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fails++; $display("FAIL add_no_busy: got %b expected 0", busy);
    end
    ForwardA = 2'b11; read_data_1 = 32'd1234; read_data_2 = 32'd1234; alu_op = 3'b001;
    #1;
    n_checks++;
    if (alu_result !== 32'd0 || zero !== 1'b1) begin
      n_fails++; $display("FAIL sub_zero: got res=%h zero=%b expected 0 zero=1", alu_result, zero);
    end
    @(negedge clk);
  endtask

  task automatic test_mult_directed();
    start_op(6'h18, 32'hFFFF_FFFD, 32'd7);
    wait_done(33);
    n_checks++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      n_fails++; $display("FAIL mult_neg3x7: got %h expected ffffffffffffffeb", {hi, lo});
    end
  endtask

  task automatic test_divu_mflo();
    start_op(6'h1B, 32'd100, 32'd7);
    wait_done(33);
    ins_15_0 = 32'h12;
    #1;
    n_checks++;
    if (alu_result !== 32'd14) begin
      n_fails++; $display("FAIL mflo_after_divu: got %0d expected 14", alu_result);
    end
    ins_15_0 = 32'h10;
    #1;
    n_checks++;
    if (alu_result !== 32'd2) begin
      n_fails++; $display("FAIL mfhi_after_divu: got %0d expected 2", alu_result);
    end
    @(negedge clk);
  endtask

  task automatic test_div_by_zero();
    start_op(6'h1A, 32'd5, 32'd0);
    wait_done(33);
    repeat (3) @(negedge clk);
    n_checks++;
    if (div_by_zero !== 1'b1) begin
      n_fails++; $display("FAIL dbz_sticky: got %b expected 1", div_by_zero);
    end
    start_op(6'h1A, 32'd9, 32'd3);
    wait_done(33);
  endtask

  task automatic test_div_overflow();
    start_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(33);
    start_op(6'h1A, 32'hFFFF_FFF9, 32'd2);
    wait_done(33);
  endtask

  task automatic test_random_muldiv();
    logic [31:0] specials [5] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] a, b;
    logic [5:0]  f;
    for (int i = 0; i < 14; i++) begin
      f = 6'h18 + 6'($urandom_range(0, 3));
      a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
      b = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 4)] : $urandom();
      if ($urandom_range(0, 2) == 0) b = b & 32'hFF;
      start_op(f, a, b);
      wait_done(33);
    end
  endtask

  task automatic test_alu_random();
    logic [5:0]  ftab [16] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h10, 6'h12,
                               6'h18, 6'h19, 6'h1A, 6'h1B, 6'h00, 6'h3F, 6'h21, 6'h11};
    logic [31:0] a, bf, b, exp, tmp;
    logic        bad_busy = 1'b0;
    valid_in = 1'b0;
    for (int i = 0; i < 200; i++) begin
      ForwardA = 2'($urandom_range(0, 3)); ForwardB = 2'($urandom_range(0, 3));
      read_data_1 = $urandom(); read_data_2 = $urandom();
      EX_MEM_alu_result = $urandom(); MEM_WB_read_data = $urandom();
      if ($urandom_range(0, 7) == 0) read_data_2 = read_data_1;
      alu_src = 1'($urandom_range(0, 1));
      alu_op  = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
      tmp = $urandom();
      tmp[5:0] = ftab[$urandom_range(0, 15)];
      ins_15_0 = tmp;
      a  = sel_src(ForwardA, read_data_1, EX_MEM_alu_result, MEM_WB_read_data);
      bf = sel_src(ForwardB, read_data_2, EX_MEM_alu_result, MEM_WB_read_data);
      b  = alu_src ? ins_15_0 : bf;
      exp = alu_model(alu_op, ins_15_0[5:0], a, b, m_hi, m_lo);
      #1;
      n_checks++;
      if (alu_result !== exp || zero !== (exp == 32'd0) || write_data !== bf) begin
        n_fails++;
        $display("FAIL alu_random op=%0d f=%h: got res=%h zero=%b wd=%h expected res=%h zero=%b wd=%h",
                 alu_op, ins_15_0[5:0], alu_result, zero, write_data, exp, (exp == 32'd0), bf);
      end
      @(negedge clk);
      if (busy !== 1'b0) bad_busy = 1'b1;
    end
    n_checks++;
    if (bad_busy) begin
      n_fails++; $display("FAIL valid_low_started_op: got busy=1 expected busy=0");
    end
  endtask

  task automatic test_busy_ignore();
    logic bad = 1'b0;
    start_op(6'h19, $urandom(), $urandom());
    repeat (5) @(negedge clk);
    read_data_1 = $urandom(); read_data_2 = $urandom(); ins_15_0 = 32'h19; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0; ins_15_0 = 32'h12;
    #1;
    n_checks++;
    if (alu_result !== m_lo) begin
      n_fails++; $display("FAIL mflo_while_busy: got %h expected %h", alu_result, m_lo);
    end
    wait_done(27);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fails++; $display("FAIL ignored_op_started: got busy/done activity expected none");
    end
  endtask

  task automatic test_reset_midop();
    logic bad = 1'b0;
    start_op(6'h18, $urandom(), $urandom());
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    n_checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || {hi, lo} !== 64'd0) begin
      n_fails++; $display("FAIL reset_midop: got busy=%b done=%b dbz=%b hilo=%h expected all 0",
                          busy, done, div_by_zero, {hi, lo});
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fails++; $display("FAIL done_after_reset: got busy/done activity expected none");
    end
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_mult_directed();
    test_divu_mflo();
    test_div_by_zero();
    test_div_overflow();
    test_random_muldiv();
    test_alu_random();
    test_busy_ignore();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
